// File: rtl/read_arbiter.sv
// AR/R channel arbiter for the 3-master / 8-slave AXI interconnect.
// Grants one master round-robin, decodes its slave and holds both muxes until RLAST.
module read_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              ARVALID_M0,
    input  logic              ARVALID_M1,
    input  logic              ARVALID_M2,
    input  logic [ADDR_W-1:0] ARADDR_M0,
    input  logic [ADDR_W-1:0] ARADDR_M1,
    input  logic [ADDR_W-1:0] ARADDR_M2,
    input  logic [LEN_W-1:0]  ARLEN_M0,
    input  logic [LEN_W-1:0]  ARLEN_M1,
    input  logic [LEN_W-1:0]  ARLEN_M2,
    input  logic              ARREADY_SEL,
    input  logic              RVALID_SEL,
    input  logic              RLAST_SEL,
    input  logic              RREADY_SEL,
    output logic [2:0]        GRANT_M,
    output logic [3:0]        SLV_SEL,
    output logic              AR_PHASE,
    output logic              R_PHASE,
    output logic              LEN_ERR
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AR,
        ST_R
    } state_t;

    localparam logic [3:0] SLV_DEFAULT = 4'd8;

    state_t            state_q;
    logic [2:0]        grant_q;
    logic [3:0]        slvSel_q;
    logic              arPhase_q;
    logic              rPhase_q;
    logic              lenErr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W:0]    beat_q;
    logic [1:0]        lastGrant_q;

    logic [2:0]        arValid;
    logic              winValid_d;
    logic [1:0]        winIdx_d;
    logic [ADDR_W-1:0] winAddr_d;
    logic [LEN_W-1:0]  winLen_d;
    logic [3:0]        winSlv_d;
    logic              grantedValid;
    logic              rBeat;
    logic              lenMatch;
    logic              unusedLowAddr;

    assign arValid = {ARVALID_M2, ARVALID_M1, ARVALID_M0};

    function automatic logic [3:0] decodeSlave(input logic [15:0] hi);
        logic [3:0] slv;
        if (hi == 16'h0000)      slv = 4'd0;
        else if (hi == 16'h0001) slv = 4'd1;
        else if (hi == 16'h0002) slv = 4'd2;
        else if (hi == 16'h1000) slv = 4'd3;
        else if (hi == 16'h1001) slv = 4'd4;
        else if (hi[15:8] == 8'h20) slv = 4'd5;
        else if (hi == 16'h0010) slv = 4'd6;
        else if (hi == 16'h0003) slv = 4'd7;
        else                     slv = SLV_DEFAULT;
        return slv;
    endfunction

    // Scan from lowest to highest priority so the master right after lastGrant wins.
    always_comb begin
        int idx;
        winValid_d = 1'b0;
        winIdx_d   = 2'd0;
        for (int k = 3; k >= 1; k--) begin
            idx = (int'(lastGrant_q) + k) % 3;
            if (arValid[idx]) begin
                winValid_d = 1'b1;
                winIdx_d   = 2'(idx);
            end
        end
    end

    always_comb begin
        winAddr_d = ARADDR_M0;
        winLen_d  = ARLEN_M0;
        case (winIdx_d)
            2'd1: begin
                winAddr_d = ARADDR_M1;
                winLen_d  = ARLEN_M1;
            end
            2'd2: begin
                winAddr_d = ARADDR_M2;
                winLen_d  = ARLEN_M2;
            end
            default: begin
                winAddr_d = ARADDR_M0;
                winLen_d  = ARLEN_M0;
            end
        endcase
    end

    assign winSlv_d      = decodeSlave(winAddr_d[ADDR_W-1 -: 16]);
    assign unusedLowAddr = ^winAddr_d[ADDR_W-17:0];
    assign grantedValid  = |(arValid & grant_q);
    assign rBeat         = RVALID_SEL & RREADY_SEL;
    assign lenMatch      = (beat_q == {1'b0, len_q});

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q     <= ST_IDLE;
            grant_q     <= 3'b000;
            slvSel_q    <= SLV_DEFAULT;
            arPhase_q   <= 1'b0;
            rPhase_q    <= 1'b0;
            lenErr_q    <= 1'b0;
            len_q       <= '0;
            beat_q      <= '0;
            lastGrant_q <= 2'd2;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (winValid_d) begin
                        state_q   <= ST_AR;
                        grant_q   <= 3'(3'b001 << winIdx_d);
                        slvSel_q  <= winSlv_d;
                        len_q     <= winLen_d;
                        arPhase_q <= 1'b1;
                    end
                end
                ST_AR: begin
                    if (grantedValid && ARREADY_SEL) begin
                        state_q   <= ST_R;
                        arPhase_q <= 1'b0;
                        rPhase_q  <= 1'b1;
                        beat_q    <= '0;
                    end
                end
                ST_R: begin
                    if (rBeat) begin
                        if (RLAST_SEL) begin
                            if (!lenMatch) lenErr_q <= 1'b1;
                            state_q     <= ST_IDLE;
                            grant_q     <= 3'b000;
                            slvSel_q    <= SLV_DEFAULT;
                            rPhase_q    <= 1'b0;
                            lastGrant_q <= {grant_q[2], grant_q[1]};
                        end else begin
                            // A non-last beat landing on the ARLEN index means RLAST is missing.
                            if (lenMatch) lenErr_q <= 1'b1;
                            if (beat_q != '1) beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign GRANT_M  = grant_q;
    assign SLV_SEL  = slvSel_q;
    assign AR_PHASE = arPhase_q;
    assign R_PHASE  = rPhase_q;
    assign LEN_ERR  = lenErr_q;

endmodule

// File: tb/tb_read_arbiter.sv
// Bench for read_arbiter: transaction-level reference model, directed scenarios
// with literal expectations, then randomized traffic compared every cycle.
module tb_read_arbiter;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        reqV [3];
    logic [31:0] reqA [3];
    logic [3:0]  reqL [3];
    logic        ARREADY_SEL = 1'b0;
    logic        RVALID_SEL = 1'b0;
    logic        RLAST_SEL = 1'b0;
    logic        RREADY_SEL = 1'b0;
    logic [2:0]  GRANT_M;
    logic [3:0]  SLV_SEL;
    logic        AR_PHASE;
    logic        R_PHASE;
    logic        LEN_ERR;

    always #5 ACLK = ~ACLK;

    read_arbiter #(.ADDR_W(32), .LEN_W(4)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARVALID_M0(reqV[0]), .ARVALID_M1(reqV[1]), .ARVALID_M2(reqV[2]),
        .ARADDR_M0(reqA[0]), .ARADDR_M1(reqA[1]), .ARADDR_M2(reqA[2]),
        .ARLEN_M0(reqL[0]), .ARLEN_M1(reqL[1]), .ARLEN_M2(reqL[2]),
        .ARREADY_SEL(ARREADY_SEL), .RVALID_SEL(RVALID_SEL),
        .RLAST_SEL(RLAST_SEL), .RREADY_SEL(RREADY_SEL),
        .GRANT_M(GRANT_M), .SLV_SEL(SLV_SEL),
        .AR_PHASE(AR_PHASE), .R_PHASE(R_PHASE), .LEN_ERR(LEN_ERR)
    );

    // Reference model: mode 0 = waiting, 1 = address owned, 2 = data owned.
    int   mMode = 0;
    int   mIdx = -1;
    int   mLast = 2;
    int   mBeat = 0;
    int   mLen = 0;
    int   mSlv = 8;
    logic mErr = 1'b0;
    int   acceptCnt [3] = '{0, 0, 0};

    int   checks = 0;
    int   errors = 0;
    bit   checkEn = 0;
    bit   keepReq = 0;
    bit   autoReq = 0;
    bit   manualSlave = 0;
    bit   randomOffsets = 0;
    int   lastOffset = 0;
    int   rTarget = 0;
    int   arReadyPct = 60;
    int   rPct = 70;
    int   seenCnt [3] = '{0, 0, 0};

    function automatic int refDecode(logic [31:0] a);
        logic [15:0] keys [7] = '{16'h0000, 16'h0001, 16'h0002, 16'h1000, 16'h1001, 16'h0010, 16'h0003};
        int          slv  [7] = '{0, 1, 2, 3, 4, 6, 7};
        if (a[31:24] == 8'h20) return 5;
        for (int i = 0; i < 7; i++) if (a[31:16] == keys[i]) return slv[i];
        return 8;
    endfunction

    function automatic int rrPick(int last);
        for (int k = 1; k <= 3; k++) if (reqV[(last + k) % 3]) return (last + k) % 3;
        return -1;
    endfunction

    always @(posedge ACLK) begin
        if (!ARESETn) begin
            mMode <= 0; mIdx <= -1; mLast <= 2; mErr <= 1'b0; mSlv <= 8; mBeat <= 0;
        end else if (mMode == 0) begin
            if (rrPick(mLast) >= 0) begin
                mMode <= 1;
                mIdx  <= rrPick(mLast);
                mSlv  <= refDecode(reqA[rrPick(mLast)]);
                mLen  <= int'(reqL[rrPick(mLast)]);
            end
        end else if (mMode == 1) begin
            if (reqV[mIdx] && ARREADY_SEL) begin
                mMode <= 2;
                mBeat <= 0;
                acceptCnt[mIdx] <= acceptCnt[mIdx] + 1;
            end
        end else if (RVALID_SEL && RREADY_SEL) begin
            if (RLAST_SEL) begin
                if (mBeat != mLen) mErr <= 1'b1;
                mLast <= mIdx; mIdx <= -1; mMode <= 0; mSlv <= 8;
            end else begin
                if (mBeat == mLen) mErr <= 1'b1;
                mBeat <= mBeat + 1;
            end
        end
    end

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeoutFail(string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out waiting, got no progress expected completion", name);
    endtask

    task automatic compareModel();
        if (!checkEn) return;
        checkOutput("model_grant", 32'(GRANT_M), (mIdx < 0) ? 32'd0 : (32'd1 << mIdx));
        checkOutput("model_slv", 32'(SLV_SEL), 32'(mSlv));
        checkOutput("model_ar_phase", 32'(AR_PHASE), 32'(mMode == 1));
        checkOutput("model_r_phase", 32'(R_PHASE), 32'(mMode == 2));
        checkOutput("model_len_err", 32'(LEN_ERR), 32'(mErr));
        checkOutput("phase_exclusive", 32'(AR_PHASE & R_PHASE), 32'd0);
    endtask

    task automatic newReq(int m, logic [31:0] a, logic [3:0] l);
        reqV[m] = 1'b1;
        reqA[m] = a;
        reqL[m] = l;
    endtask

    task automatic driveSlave();
        int offs [5] = '{0, 0, 0, -1, 1};
        int t;
        ARREADY_SEL = ($urandom_range(99) < arReadyPct);
        if (mMode == 1) begin
            t = mLen + (randomOffsets ? offs[$urandom_range(4)] : lastOffset);
            rTarget = (t < 0) ? 0 : t;
        end
        RVALID_SEL = ($urandom_range(99) < rPct);
        RREADY_SEL = ($urandom_range(99) < rPct);
        if (mMode == 2) RLAST_SEL = (mBeat >= rTarget);
        else            RLAST_SEL = 1'($urandom_range(1));
    endtask

    // One clock: compare against the model, then set inputs for the next edge.
    task automatic applyStimulus();
        logic [31:0] addrs [11] = '{32'h0000_0100, 32'h0001_2000, 32'h0002_0040, 32'h1000_0000,
                                    32'h1001_0004, 32'h2000_0000, 32'h20FF_FFF0, 32'h0010_0000,
                                    32'h0003_0010, 32'h4000_0000, 32'h0004_0000};
        @(negedge ACLK);
        compareModel();
        for (int i = 0; i < 3; i++) begin
            if (acceptCnt[i] != seenCnt[i]) begin
                seenCnt[i] = acceptCnt[i];
                reqV[i] = keepReq;
            end
            if (autoReq && !reqV[i] && $urandom_range(3) == 0)
                newReq(i, addrs[$urandom_range(10)] | 32'($urandom_range(255)), 4'($urandom_range(15)));
        end
        if (!manualSlave) driveSlave();
    endtask

    task automatic doReset();
        ARESETn = 1'b0;
        for (int i = 0; i < 3; i++) reqV[i] = 1'b0;
        applyStimulus();
        applyStimulus();
        ARESETn = 1'b1;
    endtask

    task automatic waitAllDone(string name);
        for (int n = 0; n < 3000; n++) begin
            applyStimulus();
            if (mMode == 0 && !reqV[0] && !reqV[1] && !reqV[2]) return;
        end
        timeoutFail(name);
    endtask

    task automatic runOne(int m, logic [31:0] a, logic [3:0] l, int expSlv);
        bit granted = 0;
        newReq(m, a, l);
        for (int n = 0; n < 50 && !granted; n++) begin
            applyStimulus();
            granted = (GRANT_M != 3'b000);
        end
        if (!granted) timeoutFail("run_grant");
        checkOutput("run_grant_id", 32'(GRANT_M), 32'd1 << m);
        checkOutput("run_slv_sel", 32'(SLV_SEL), 32'(expSlv));
        waitAllDone("run_finish");
    endtask

    initial begin
        int gotGrants [$];
        logic [2:0] prevG;
        int expOrder [4] = '{1, 2, 4, 1};
        for (int i = 0; i < 3; i++) begin
            reqV[i] = 1'b0; reqA[i] = '0; reqL[i] = '0;
        end

        applyStimulus();
        checkEn = 1;
        doReset();
        checkOutput("reset_grant", 32'(GRANT_M), 32'd0);
        checkOutput("reset_slv", 32'(SLV_SEL), 32'd8);
        checkOutput("reset_phases", 32'({AR_PHASE, R_PHASE}), 32'd0);
        checkOutput("reset_len_err", 32'(LEN_ERR), 32'd0);

        // Single-beat read by M1 with a hand-driven slave.
        manualSlave = 1;
        ARREADY_SEL = 0; RVALID_SEL = 0; RREADY_SEL = 0; RLAST_SEL = 0;
        newReq(1, 32'h0002_0040, 4'd0);
        applyStimulus();
        checkOutput("t1_grant", 32'(GRANT_M), 32'b010);
        checkOutput("t1_slv", 32'(SLV_SEL), 32'd2);
        checkOutput("t1_ar_phase", 32'(AR_PHASE), 32'd1);
        applyStimulus();
        checkOutput("t1_ar_hold", 32'(AR_PHASE), 32'd1);
        ARREADY_SEL = 1;
        applyStimulus();
        checkOutput("t1_r_phase", 32'({AR_PHASE, R_PHASE}), 32'b01);
        ARREADY_SEL = 0; RVALID_SEL = 1; RREADY_SEL = 1; RLAST_SEL = 1;
        applyStimulus();
        checkOutput("t1_idle_grant", 32'(GRANT_M), 32'd0);
        checkOutput("t1_idle_slv", 32'(SLV_SEL), 32'd8);
        checkOutput("t1_idle_r", 32'(R_PHASE), 32'd0);
        checkOutput("t1_len_err", 32'(LEN_ERR), 32'd0);
        RVALID_SEL = 0; RREADY_SEL = 0; RLAST_SEL = 0;
        manualSlave = 0;

        // All masters requesting continuously; round-robin order from reset.
        doReset();
        keepReq = 1;
        newReq(0, 32'h0000_0010, 4'd3);
        newReq(1, 32'h0001_0020, 4'd3);
        newReq(2, 32'h2000_0030, 4'd3);
        prevG = 3'b000;
        for (int n = 0; n < 500 && gotGrants.size() < 4; n++) begin
            applyStimulus();
            if (GRANT_M != 3'b000 && prevG == 3'b000) gotGrants.push_back(int'(GRANT_M));
            prevG = GRANT_M;
        end
        if (gotGrants.size() < 4) timeoutFail("rr_order");
        for (int i = 0; i < 4 && i < gotGrants.size(); i++)
            checkOutput($sformatf("rr_order_%0d", i), 32'(gotGrants[i]), 32'(expOrder[i]));
        keepReq = 0;
        waitAllDone("rr_drain");
        checkOutput("rr_len_err", 32'(LEN_ERR), 32'd0);

        // Decode sweep.
        runOne(0, 32'h0000_0000, 4'd0, 0);
        runOne(0, 32'h1001_0000, 4'd1, 4);
        runOne(0, 32'h2010_0000, 4'd0, 5);
        runOne(0, 32'h0010_0000, 4'd2, 6);
        runOne(0, 32'h0003_0000, 4'd0, 7);
        runOne(0, 32'h4000_0000, 4'd1, 8);

        // Early RLAST sets the sticky error; a clean burst afterwards keeps it.
        lastOffset = -2;
        runOne(0, 32'h0001_0000, 4'd3, 1);
        checkOutput("early_last_err", 32'(LEN_ERR), 32'd1);
        lastOffset = 0;
        runOne(1, 32'h1000_0000, 4'd2, 3);
        checkOutput("sticky_err", 32'(LEN_ERR), 32'd1);

        // Late RLAST.
        doReset();
        lastOffset = 1;
        runOne(2, 32'h0003_0000, 4'd1, 7);
        checkOutput("late_last_err", 32'(LEN_ERR), 32'd1);
        lastOffset = 0;

        // Reset in the middle of a DRAM burst.
        doReset();
        newReq(1, 32'h2000_1000, 4'd15);
        for (int n = 0; n < 100 && mMode != 2; n++) applyStimulus();
        if (mMode != 2) timeoutFail("midreset_reach_r");
        applyStimulus();
        ARESETn = 1'b0;
        applyStimulus();
        checkOutput("midreset_grant", 32'(GRANT_M), 32'd0);
        checkOutput("midreset_slv", 32'(SLV_SEL), 32'd8);
        checkOutput("midreset_phases", 32'({AR_PHASE, R_PHASE}), 32'd0);
        ARESETn = 1'b1;
        newReq(0, 32'h0000_0200, 4'd1);
        newReq(1, 32'h0002_0200, 4'd1);
        applyStimulus();
        checkOutput("postreset_m0_first", 32'(GRANT_M), 32'b001);
        waitAllDone("postreset_drain");

        // Randomized traffic.
        doReset();
        autoReq = 1;
        randomOffsets = 1;
        for (int n = 0; n < 3000; n++) begin
            if (n % 500 == 0) begin
                arReadyPct = $urandom_range(20, 100);
                rPct = $urandom_range(30, 100);
            end
            applyStimulus();
        end
        autoReq = 0;
        randomOffsets = 0;
        rPct = 80;
        waitAllDone("random_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
